dsp_sweep_sequencer: RTL
========================

Name: dsp_sweep_sequencer

Overview:
Synthesizable, parametrised stimulus sequencer and signature checker for the dsp_top slice.
- Sweeps a configurable opmode x alumode window and drives incrementing A/B/C/D operand ramps.
- Holds each combination for PIPELINE cycles so the slice output settles, then compresses P into a MISR signature.
- Replaces hand-written sweeps for on-chip/regression self-test; sits beside dsp_top and drives its data and control inputs directly.

Parameters:
A_WIDTH, 30, width of a
B_WIDTH, 18, width of b
C_WIDTH, 48, width of c
D_WIDTH, 25, width of d
P_WIDTH, 48, width of p and signature
PIPELINE, 3, hold cycles per combination (>=1); set to slice latency
RST_CYCLES, 1, cycles dsp_rst is asserted at sweep start (>=1)
OPMODE_FIRST, 0, first opmode (7-bit)
OPMODE_LAST, 127, last opmode (>= OPMODE_FIRST)
ALUMODE_FIRST, 0, first alumode (4-bit)
ALUMODE_LAST, 15, last alumode (>= ALUMODE_FIRST)
INMODE, 4, constant inmode value
A_INIT / B_INIT / C_INIT / D_INIT, 5 / 7 / 12 / 7, operand start values
STEP, 1, operand increment per combination

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins sweep from IDLE or DONE
abort  in  1  pulse; returns to IDLE
p  in  P_WIDTH  slice result
a / b / c / d  out  A/B/C/D_WIDTH  operand ramps
opmode  out  7  current opmode
alumode  out  4  current alumode
inmode  out  5  constant INMODE
dsp_rst  out  1  active-high reset to all slice registers
busy  out  1  high in RESET or RUN
done  out  1  high in DONE
signature  out  P_WIDTH  MISR of captured p
vec_count  out  12  captures completed

Behaviour:
- Reset (rst_n low, async): state IDLE; a/b/c/d = *_INIT; opmode = OPMODE_FIRST; alumode = ALUMODE_FIRST; inmode = INMODE; dsp_rst = 1; busy = 0; done = 0; signature = 0; vec_count = 0; hold counter = 0.
- States: IDLE, RESET, RUN, DONE. All outputs are registered.
- IDLE:
  - dsp_rst = 1.
  - start (without abort) -> RESET: operands reload *_INIT, opmode/alumode reload FIRST, signature and vec_count clear.
- RESET:
  - dsp_rst = 1 for exactly RST_CYCLES cycles, then -> RUN with dsp_rst = 0 and hold counter = 0.
- RUN:
  - Hold counter counts 0..PIPELINE-1.
  - On the edge where hold = PIPELINE-1:
    - signature <= {signature[P_WIDTH-2:0], signature[P_WIDTH-1]} ^ p.
    - vec_count += 1.
    - a/b/c/d += STEP, each wrapping modulo 2^width.
    - If alumode != ALUMODE_LAST: alumode += 1.
    - Otherwise: alumode = ALUMODE_FIRST and opmode += 1.
    - If opmode = OPMODE_LAST and alumode = ALUMODE_LAST: -> DONE instead, with operands/opmode/alumode frozen at their last values.
  - Captures per sweep = (OPMODE_LAST-OPMODE_FIRST+1)*(ALUMODE_LAST-ALUMODE_FIRST+1); the default is 2048.
  - Sweep length in cycles = RST_CYCLES + captures*PIPELINE.
- DONE:
  - done = 1, busy = 0, dsp_rst = 0; signature and vec_count hold.
  - start -> RESET (restart, done drops).
- start while busy: ignored.
- abort in any state: -> IDLE next edge; done = 0, dsp_rst = 1; signature/vec_count retained for inspection.
- start and abort in the same cycle: abort wins.
- rst_n asserted mid-sweep: immediate return to reset values.
- PIPELINE = 1: one capture per cycle with no idle cycles.

Test Plan:
- Defaults, p tied 0: start -> busy=1, dsp_rst high 1 cycle, done=1 after 1+2048*3 = 6145 cycles; vec_count=2048, signature=0.
- OPMODE 0..1, ALUMODE 0..1, PIPELINE 2, p tied 1 -> (opmode,alumode) sequence (0,0),(0,1),(1,0),(1,1), each held 2 cycles; vec_count=4; signature=0xF.
- A_WIDTH 4, A_INIT 15, STEP 1 -> a=15 for first combination, a=0 after first capture (wrap).
- abort during RUN after 3 captures -> IDLE next cycle, busy=0, dsp_rst=1, vec_count=3 retained; start+abort same cycle from IDLE -> stays IDLE.
- rst_n low mid-sweep -> all outputs at reset values immediately, asynchronous to clk; start after release -> full sweep repeats with identical signature.
- start pulse while busy -> no effect on sequence or vec_count; start in DONE -> restart, done=0, signature cleared.

Source files
------------

// File: rtl/dsp_sweep_sequencer_if.sv
// dsp_sweep_sequencer_if: control, operand and result bundle between the sweep sequencer and its dsp slice.
interface dsp_sweep_sequencer_if #(
    parameter int A_WIDTH = 30,
    parameter int B_WIDTH = 18,
    parameter int C_WIDTH = 48,
    parameter int D_WIDTH = 25,
    parameter int P_WIDTH = 48
);
    logic               start;
    logic               abort;
    logic [P_WIDTH-1:0] p;
    logic [A_WIDTH-1:0] a;
    logic [B_WIDTH-1:0] b;
    logic [C_WIDTH-1:0] c;
    logic [D_WIDTH-1:0] d;
    logic [6:0]         opmode;
    logic [3:0]         alumode;
    logic [4:0]         inmode;
    logic               dsp_rst;
    logic               busy;
    logic               done;
    logic [P_WIDTH-1:0] signature;
    logic [11:0]        vec_count;

    modport master (
        input  start, abort, p,
        output a, b, c, d, opmode, alumode, inmode, dsp_rst, busy, done, signature, vec_count
    );

    modport slave (
        output start, abort, p,
        input  a, b, c, d, opmode, alumode, inmode, dsp_rst, busy, done, signature, vec_count
    );
endinterface

// File: rtl/dsp_sweep_sequencer.sv
// dsp_sweep_sequencer: sweeps opmode x alumode with ramping operands, holding each
// combination PIPELINE cycles before folding the slice result into a MISR signature.
module dsp_sweep_sequencer #(
    parameter int A_WIDTH       = 30,
    parameter int B_WIDTH       = 18,
    parameter int C_WIDTH       = 48,
    parameter int D_WIDTH       = 25,
    parameter int P_WIDTH       = 48,
    parameter int PIPELINE      = 3,
    parameter int RST_CYCLES    = 1,
    parameter int OPMODE_FIRST  = 0,
    parameter int OPMODE_LAST   = 127,
    parameter int ALUMODE_FIRST = 0,
    parameter int ALUMODE_LAST  = 15,
    parameter int INMODE        = 4,
    parameter int A_INIT        = 5,
    parameter int B_INIT        = 7,
    parameter int C_INIT        = 12,
    parameter int D_INIT        = 7,
    parameter int STEP          = 1
) (
    input logic                   clk,
    input logic                   rst_n,
    dsp_sweep_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;

    localparam int HW = PIPELINE > 1 ? $clog2(PIPELINE) : 1;
    localparam int RW = RST_CYCLES > 1 ? $clog2(RST_CYCLES) : 1;

    state_t             state;
    logic [HW-1:0]      hold;
    logic [RW-1:0]      rcnt;
    logic [A_WIDTH-1:0] a;
    logic [B_WIDTH-1:0] b;
    logic [C_WIDTH-1:0] c;
    logic [D_WIDTH-1:0] d;
    logic [6:0]         opmode;
    logic [3:0]         alumode;
    logic [4:0]         inmode;
    logic               dsp_rst;
    logic               busy;
    logic               done;
    logic [P_WIDTH-1:0] signature;
    logic [11:0]        vec_count;
    logic               last_comb;

    assign last_comb = opmode == 7'(OPMODE_LAST) && alumode == 4'(ALUMODE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold      <= '0;
            rcnt      <= '0;
            a         <= A_WIDTH'(A_INIT);
            b         <= B_WIDTH'(B_INIT);
            c         <= C_WIDTH'(C_INIT);
            d         <= D_WIDTH'(D_INIT);
            opmode    <= 7'(OPMODE_FIRST);
            alumode   <= 4'(ALUMODE_FIRST);
            inmode    <= 5'(INMODE);
            dsp_rst   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            signature <= '0;
            vec_count <= '0;
        end else if (bus.abort) begin
            // signature and vec_count stay visible after an abort
            state   <= IDLE;
            hold    <= '0;
            dsp_rst <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (bus.start && (state == IDLE || state == DONE)) begin
            state     <= RESET;
            hold      <= '0;
            rcnt      <= '0;
            a         <= A_WIDTH'(A_INIT);
            b         <= B_WIDTH'(B_INIT);
            c         <= C_WIDTH'(C_INIT);
            d         <= D_WIDTH'(D_INIT);
            opmode    <= 7'(OPMODE_FIRST);
            alumode   <= 4'(ALUMODE_FIRST);
            dsp_rst   <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            signature <= '0;
            vec_count <= '0;
        end else if (state == RESET) begin
            if (rcnt == RW'(RST_CYCLES - 1)) begin
                state   <= RUN;
                dsp_rst <= 1'b0;
                hold    <= '0;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
        end else if (state == RUN) begin
            if (hold == HW'(PIPELINE - 1)) begin
                hold      <= '0;
                signature <= {signature[P_WIDTH-2:0], signature[P_WIDTH-1]} ^ bus.p;
                vec_count <= vec_count + 12'd1;
                if (last_comb) begin
                    // final combination: operands stay frozen for inspection
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    a <= a + A_WIDTH'(STEP);
                    b <= b + B_WIDTH'(STEP);
                    c <= c + C_WIDTH'(STEP);
                    d <= d + D_WIDTH'(STEP);
                    if (alumode != 4'(ALUMODE_LAST)) begin
                        alumode <= alumode + 4'd1;
                    end else begin
                        alumode <= 4'(ALUMODE_FIRST);
                        opmode  <= opmode + 7'd1;
                    end
                end
            end else begin
                hold <= hold + 1'b1;
            end
        end
    end

    assign bus.a         = a;
    assign bus.b         = b;
    assign bus.c         = c;
    assign bus.d         = d;
    assign bus.opmode    = opmode;
    assign bus.alumode   = alumode;
    assign bus.inmode    = inmode;
    assign bus.dsp_rst   = dsp_rst;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.signature = signature;
    assign bus.vec_count = vec_count;
endmodule
